// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared predictor mode enum and static-prediction helper
package bp_pkg;

    typedef enum logic [1:0] {
        BP_BTFNT  = 2'd0,
        BP_GSHARE = 2'd1,
        BP_LSHARE = 2'd2,
        BP_TOURN  = 2'd3
    } bp_mode_e;

    // Backward-taken / forward-not-taken static direction
    function automatic logic btfnt_taken(input logic [31:0] pc, input logic [31:0] taddr);
        return taddr < (pc + 32'd4);
    endfunction

endpackage

// File: rtl/sat_table.sv
// rtl/sat_table.sv - saturating counter table with valid bits and init-on-invalid training
module sat_table #(
    parameter int IWIDTH = 6,
    parameter int CWIDTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IWIDTH-1:0] rd_idx,
    output logic              rd_taken,
    output logic              rd_valid,
    input  logic              train_en,
    input  logic [IWIDTH-1:0] train_idx,
    input  logic              train_taken
);
    localparam int N = 1 << IWIDTH;
    localparam logic [CWIDTH-1:0] WEAK_T  = CWIDTH'(1 << (CWIDTH - 1));
    localparam logic [CWIDTH-1:0] WEAK_NT = WEAK_T - 1'b1;
    localparam logic [CWIDTH-1:0] CMAX    = '1;

    logic [CWIDTH-1:0] cnt [N];
    logic [N-1:0]      valid;
    logic [CWIDTH-1:0] cur;
    logic [CWIDTH-1:0] nxt;

    assign rd_taken = cnt[rd_idx][CWIDTH-1];
    assign rd_valid = valid[rd_idx];

    always_comb begin
        cur = cnt[train_idx];
        nxt = cur;
        if (!valid[train_idx])
            nxt = train_taken ? WEAK_T : WEAK_NT;
        else if (train_taken)
            nxt = (cur == CMAX) ? cur : cur + 1'b1;
        else
            nxt = (cur == '0) ? cur : cur - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            valid <= '0;
        else if (train_en)
            valid[train_idx] <= 1'b1;
    end

    // Counter contents need no reset: they are ignored until the valid bit is set
    always_ff @(posedge clk) begin
        if (train_en)
            cnt[train_idx] <= nxt;
    end

endmodule

// File: rtl/tournament_bp.sv
// rtl/tournament_bp.sv - gshare/lshare/BTFNT tournament predictor with checkpoint queue
module tournament_bp
    import bp_pkg::*;
#(
    parameter int IWIDTH = 6,
    parameter int HWIDTH = 6,
    parameter int CWIDTH = 2,
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic        lookup_valid,
    input  logic        lookup_is_br,
    input  logic [31:0] lookup_pc,
    input  logic [31:0] lookup_taddr,
    output logic        lookup_ready,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    output logic        mispredict,
    output logic        err
);
    localparam int N  = 1 << IWIDTH;
    localparam int QW = $clog2(QDEPTH);

    typedef struct packed {
        logic [IWIDTH-1:0] idx;
        logic [IWIDTH-1:0] gidx;
        logic [IWIDTH-1:0] lidx;
        logic [HWIDTH-1:0] snap;
        logic              gpred;
        logic              lpred;
        logic              pred;
    } ckpt_t;

    logic [HWIDTH-1:0] ghr;
    logic [HWIDTH-1:0] bht [N];
    ckpt_t             q [QDEPTH];
    logic [QW:0]       wptr, rptr, count;
    logic              empty, push, pop;
    ckpt_t             head;

    logic [IWIDTH-1:0] idx, gidx, lidx;
    logic              static_t, gpred, lpred, sel_t;
    logic              g_t, g_v, l_t, l_v, c_t, c_v;

    assign idx  = lookup_pc[IWIDTH+1:2];
    assign gidx = idx ^ IWIDTH'(ghr);
    assign lidx = idx ^ IWIDTH'(bht[idx]);

    assign count = wptr - rptr;
    assign empty = (count == '0);
    assign head  = q[rptr[QW-1:0]];

    sat_table #(.IWIDTH(IWIDTH), .CWIDTH(CWIDTH)) u_gshare (
        .clk(clk), .reset(reset),
        .rd_idx(gidx), .rd_taken(g_t), .rd_valid(g_v),
        .train_en(pop), .train_idx(head.gidx), .train_taken(resolve_taken)
    );

    sat_table #(.IWIDTH(IWIDTH), .CWIDTH(CWIDTH)) u_lshare (
        .clk(clk), .reset(reset),
        .rd_idx(lidx), .rd_taken(l_t), .rd_valid(l_v),
        .train_en(pop), .train_idx(head.lidx), .train_taken(resolve_taken)
    );

    // Chooser counts toward lshare whenever lshare was the component that got it right
    sat_table #(.IWIDTH(IWIDTH), .CWIDTH(CWIDTH)) u_chooser (
        .clk(clk), .reset(reset),
        .rd_idx(idx), .rd_taken(c_t), .rd_valid(c_v),
        .train_en(pop && (head.gpred != head.lpred)), .train_idx(head.idx),
        .train_taken(head.lpred == resolve_taken)
    );

    always_comb begin
        static_t = btfnt_taken(lookup_pc, lookup_taddr);
        gpred    = g_v ? g_t : static_t;
        lpred    = l_v ? l_t : static_t;
        case (mode)
            BP_BTFNT:  sel_t = static_t;
            BP_GSHARE: sel_t = gpred;
            BP_LSHARE: sel_t = lpred;
            default:   sel_t = (c_v && c_t) ? lpred : gpred;
        endcase
        pred_taken = lookup_valid && lookup_is_br && sel_t;
        pred_pc    = pred_taken ? lookup_taddr : lookup_pc + 32'd4;
    end

    assign mispredict   = resolve_valid && !empty && (resolve_taken != head.pred);
    assign lookup_ready = !count[QW] || (resolve_valid && !mispredict && !empty);
    assign pop          = resolve_valid && en && !empty;
    assign push         = lookup_valid && lookup_is_br && lookup_ready && en
                          && !(resolve_valid && mispredict);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            ghr  <= '0;
            err  <= 1'b0;
            for (int i = 0; i < N; i++)
                bht[i] <= '0;
        end else if (en) begin
            if (resolve_valid && empty)
                err <= 1'b1;
            if (mispredict) begin
                // Everything younger than the head is wrong-path: drop it all
                rptr <= wptr;
                ghr  <= HWIDTH'({head.snap, resolve_taken});
            end else begin
                if (pop)
                    rptr <= rptr + 1'b1;
                if (push) begin
                    wptr <= wptr + 1'b1;
                    ghr  <= HWIDTH'({ghr, pred_taken});
                end
            end
            if (pop)
                bht[head.idx] <= HWIDTH'({bht[head.idx], resolve_taken});
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            q[wptr[QW-1:0]] <= '{idx: idx, gidx: gidx, lidx: lidx, snap: ghr,
                                 gpred: gpred, lpred: lpred, pred: pred_taken};
    end

endmodule

// File: tb/tb_tournament_bp.sv
// tb/tb_tournament_bp.sv - directed self-checking bench for tournament_bp
module tb_tournament_bp;

    logic        clk = 1'b0;
    logic        reset, en;
    logic [1:0]  mode;
    logic        lookup_valid, lookup_is_br, lookup_ready, pred_taken;
    logic [31:0] lookup_pc, lookup_taddr, pred_pc;
    logic        resolve_valid, resolve_taken, mispredict, err;

    int checks = 0;
    int errors = 0;

    tournament_bp #(.IWIDTH(6), .HWIDTH(2), .CWIDTH(2), .QDEPTH(4)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .lookup_valid(lookup_valid), .lookup_is_br(lookup_is_br),
        .lookup_pc(lookup_pc), .lookup_taddr(lookup_taddr),
        .lookup_ready(lookup_ready), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .mispredict(mispredict), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lookup_valid  = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input logic [31:0] ta);
        lookup_valid = 1'b1;
        lookup_is_br = 1'b1;
        lookup_pc    = pc;
        lookup_taddr = ta;
    endtask

    task automatic push_br(input string tag, input logic [31:0] pc, input logic [31:0] ta,
                           input logic exp_t);
        look(pc, ta);
        resolve_valid = 1'b0;
        #1;
        check(tag, 32'(pred_taken), 32'(exp_t));
        step();
        idle();
    endtask

    task automatic resolve(input string tag, input logic taken, input logic exp_mis);
        lookup_valid  = 1'b0;
        resolve_valid = 1'b1;
        resolve_taken = taken;
        #1;
        check(tag, 32'(mispredict), 32'(exp_mis));
        step();
        idle();
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; mode = 2'd1;
        lookup_valid = 1'b0; lookup_is_br = 1'b0; lookup_pc = '0; lookup_taddr = '0;
        resolve_valid = 1'b0; resolve_taken = 1'b0;
        #12 reset = 1'b0;
        #1;
        check("rst_ready", 32'(lookup_ready), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mis", 32'(mispredict), 32'd0);

        // Static fallback with empty tables
        look(32'h100, 32'hF0); #1;
        check("back_taken", 32'(pred_taken), 32'd1);
        check("back_pc", pred_pc, 32'hF0);
        lookup_taddr = 32'h200; #1;
        check("fwd_pc", pred_pc, 32'h104);
        lookup_valid = 1'b0; lookup_taddr = 32'hF0; #1;
        check("novalid_pc", pred_pc, 32'h104);

        // Loop branch: gshare[3] saturates, then a not-taken outcome mispredicts
        for (int i = 0; i < 5; i++) begin
            push_br("loop_pred", 32'h100, 32'hF0, 1'b1);
            resolve("loop_res", 1'b1, 1'b0);
        end
        push_br("loop_sat_pred", 32'h100, 32'hF0, 1'b1);
        resolve("loop_exit_mis", 1'b0, 1'b1);
        look(32'h100, 32'h200); #1;
        check("ghr_restore_10", 32'(pred_taken), 32'd0);
        idle();

        // Fill the queue, then a concurrent correct resolve keeps it full
        mode = 2'd0;
        for (int i = 0; i < 4; i++)
            push_br("fill", 32'h100, 32'hF0, 1'b1);
        look(32'h100, 32'h200); #1;
        check("full_ready", 32'(lookup_ready), 32'd0);
        check("full_pc", pred_pc, 32'h104);
        step();
        check("full_ready2", 32'(lookup_ready), 32'd0);
        mode = 2'd1; #1;
        check("full_ghr_hold", 32'(pred_taken), 32'd1);
        mode = 2'd0;
        look(32'h100, 32'hF0);
        resolve_valid = 1'b1; resolve_taken = 1'b1; #1;
        check("conc_ready", 32'(lookup_ready), 32'd1);
        check("conc_mis", 32'(mispredict), 32'd0);
        step(); idle(); #1;
        check("conc_count_kept", 32'(lookup_ready), 32'd0);
        resolve("drain1", 1'b1, 1'b0);

        // Three in flight, oldest mispredicts with a lookup in the same cycle
        look(32'h100, 32'hF0);
        resolve_valid = 1'b1; resolve_taken = 1'b0; #1;
        check("flush_mis", 32'(mispredict), 32'd1);
        step(); idle();
        mode = 2'd1;
        look(32'h100, 32'h200); #1;
        check("flush_ghr", 32'(pred_taken), 32'd1);
        idle();

        // Resolve on empty queue
        resolve_valid = 1'b1; resolve_taken = 1'b0; #1;
        check("empty_mis", 32'(mispredict), 32'd0);
        step(); idle();
        check("empty_err", 32'(err), 32'd1);
        check("empty_ready", 32'(lookup_ready), 32'd1);

        // Tournament: chooser learns that lshare is right at idx 8
        mode = 2'd3;
        push_br("ch1", 32'h120, 32'h110, 1'b1);
        resolve("ch1_res", 1'b0, 1'b1);
        push_br("ch2_gsel", 32'h120, 32'h110, 1'b1);
        resolve("ch2_res", 1'b0, 1'b1);
        push_br("ch3_agree", 32'h120, 32'h110, 1'b0);
        resolve("ch3_res", 1'b0, 1'b0);
        push_br("chC", 32'h100, 32'hF0, 1'b1);
        look(32'h120, 32'h110); #1;
        check("ch_lsel", 32'(pred_taken), 32'd0);
        check("ch_lsel_pc", pred_pc, 32'h124);
        step(); idle();
        resolve("chC_res", 1'b1, 1'b0);
        resolve("chB_res", 1'b0, 1'b0);

        // Asynchronous reset mid-stream with a full queue and err set
        mode = 2'd0;
        for (int i = 0; i < 4; i++)
            push_br("refill", 32'h100, 32'hF0, 1'b1);
        check("refill_ready", 32'(lookup_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("async_ready", 32'(lookup_ready), 32'd1);
        check("async_err", 32'(err), 32'd0);
        reset = 1'b0;

        // Stall freezes err
        en = 1'b0;
        resolve_valid = 1'b1; resolve_taken = 1'b0;
        step(); idle();
        check("stall_err", 32'(err), 32'd0);
        en = 1'b1;
        resolve_valid = 1'b1;
        step(); idle();
        check("unstall_err", 32'(err), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
